// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      OPC  = 3'd1,
      DHI  = 3'd2,
      DLO  = 3'd3,
      CHK  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_CHK  = 2'd1,
      ERR_TMO  = 2'd2,
      ERR_OVR  = 2'd3
   } err_t;

   localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hAA;

   // Expected CHK byte for a given running sum of OPCODE, DATA_HI, DATA_LO.
   function automatic logic [7:0] frame_chk(input logic [7:0] sum);
      return ~sum;
   endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout down-counter: clr reloads, run counts down, expired flags zero while running.
module uart_byte_timer #(
   parameter int CYCLES = 52080
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int W = $clog2(CYCLES + 1);
   localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

   logic [W-1:0] cnt;

   // Remaining-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end else begin
         cnt <= cnt;
      end
   end

   assign expired = run && (cnt == '0);

endmodule

// File: rtl/uart_cmd_framer.sv
// Assembles UART bytes into HDR/OPCODE/DATA_HI/DATA_LO/CHK command frames.
// Optional saturating error counter enabled by macro UART_CMD_ERR_CNT_EN.
module uart_cmd_framer #(
   parameter logic [7:0] HDR_BYTE       = uart_cmd_pkg::HDR_BYTE_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 52080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_rdy,
   output logic        clr_rx_rdy,
   output logic [7:0]  cmd_opcode,
   output logic [15:0] cmd_data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [7:0]  err_cnt
);

   import uart_cmd_pkg::*;

   state_t     state;
   state_t     next_state;
   logic [7:0] opc_byte;
   logic [7:0] dhi_byte;
   logic [7:0] dlo_byte;
   logic [7:0] sum;
   logic       accept;
   logic       expired;
   logic       commit;
   logic       chk_err;
   logic       tmo;
   logic       overrun;
   logic       err_set;
   err_t       err_next;
   err_t       err_reg;

   // The cycle after an accept is blanked by clr_rx_rdy, so a held rx_rdy is consumed once.
   assign accept = rx_rdy && !clr_rx_rdy;

   uart_byte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept || (state == IDLE)),
      .run     (state != IDLE),
      .expired (expired)
   );

   // Next-state and frame-event decode.
   always_comb begin
      next_state = state;
      commit     = 1'b0;
      chk_err    = 1'b0;
      tmo        = 1'b0;
      case (state)
         IDLE: begin
            if (accept && (rx_data == HDR_BYTE)) begin
               next_state = OPC;
            end else begin
               next_state = IDLE;
            end
         end
         OPC, DHI, DLO: begin
            if (accept) begin
               next_state = (state == OPC) ? DHI : ((state == DHI) ? DLO : CHK);
            end else if (expired) begin
               next_state = IDLE;
               tmo        = 1'b1;
            end else begin
               next_state = state;
            end
         end
         CHK: begin
            if (accept) begin
               next_state = IDLE;
               if (rx_data == frame_chk(sum)) begin
                  commit = 1'b1;
               end else begin
                  chk_err = 1'b1;
               end
            end else if (expired) begin
               next_state = IDLE;
               tmo        = 1'b1;
            end else begin
               next_state = CHK;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // A simultaneous clear means the consumer has taken the old frame, so no overrun.
   assign overrun  = commit && cmd_rdy && !clr_cmd_rdy;
   assign err_set  = chk_err || tmo || overrun;
   assign err_next = chk_err ? ERR_CHK : (tmo ? ERR_TMO : ERR_OVR);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Frame byte capture and running checksum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opc_byte <= 8'h00;
         dhi_byte <= 8'h00;
         dlo_byte <= 8'h00;
         sum      <= 8'h00;
      end else if (accept) begin
         case (state)
            OPC: begin
               opc_byte <= rx_data;
               sum      <= rx_data;
            end
            DHI: begin
               dhi_byte <= rx_data;
               sum      <= sum + rx_data;
            end
            DLO: begin
               dlo_byte <= rx_data;
               sum      <= sum + rx_data;
            end
            default: begin
               sum <= sum;
            end
         endcase
      end else begin
         sum <= sum;
      end
   end

   // Registered handshake, command and error outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_rx_rdy <= 1'b0;
         cmd_opcode <= 8'h00;
         cmd_data   <= 16'h0000;
         cmd_rdy    <= 1'b0;
         frame_err  <= 1'b0;
         err_reg    <= ERR_NONE;
      end else begin
         clr_rx_rdy <= accept;
         frame_err  <= err_set;
         err_reg    <= err_set ? err_next : err_reg;
         if (commit) begin
            cmd_opcode <= opc_byte;
            cmd_data   <= {dhi_byte, dlo_byte};
            cmd_rdy    <= 1'b1;
         end else if (clr_cmd_rdy) begin
            cmd_rdy    <= 1'b0;
         end else begin
            cmd_rdy    <= cmd_rdy;
         end
      end
   end

   assign err_code = err_reg;

`ifdef UART_CMD_ERR_CNT_EN
   logic [7:0] err_cnt_reg;

   // Saturating error counter; a new error takes priority over the consumer clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_reg <= 8'h00;
      end else if (err_set) begin
         err_cnt_reg <= (err_cnt_reg == 8'hFF) ? 8'hFF : (err_cnt_reg + 8'h01);
      end else if (clr_cmd_rdy) begin
         err_cnt_reg <= 8'h00;
      end else begin
         err_cnt_reg <= err_cnt_reg;
      end
   end

   assign err_cnt = err_cnt_reg;
`else
   assign err_cnt = 8'h00;
`endif

endmodule
